// File: rtl/gcd_requester_if.sv
// Handshake bundle between the GCD requester, its upstream producer,
// its downstream consumer and the subtractive GCD engine.
// The master side is the requester; the slave side is everything around it.
interface gcd_requester_if #(
   parameter int WIDTH = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_gcd;
   logic             rsp_err;

   logic             eng_start;
   logic [WIDTH-1:0] eng_ina;
   logic [WIDTH-1:0] eng_inb;
   logic             eng_ready;
   logic [WIDTH-1:0] eng_out;

   modport master (
      input  req_valid, req_a, req_b, rsp_ready, eng_ready, eng_out,
      output req_ready, rsp_valid, rsp_gcd, rsp_err, eng_start, eng_ina, eng_inb
   );

   modport slave (
      output req_valid, req_a, req_b, rsp_ready, eng_ready, eng_out,
      input  req_ready, rsp_valid, rsp_gcd, rsp_err, eng_start, eng_ina, eng_inb
   );
endinterface

// File: rtl/gcd_requester.sv
// Client-side sequencer for the subtractive GCD engine.
// Takes operand pairs from upstream, answers zero-operand jobs locally,
// otherwise starts the engine, waits for a genuine busy->idle completion,
// and presents the result downstream. Every engine job is bounded by a
// saturating cycle counter; an expired job returns rsp_err=1, rsp_gcd=0.
module gcd_requester #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              nrst,
   gcd_requester_if.master   bus,
   output logic              busy
);
   localparam int                CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      RESP
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   eng_ina_q, eng_ina_d;
   logic [WIDTH-1:0]   eng_inb_q, eng_inb_d;
   logic [WIDTH-1:0]   rsp_gcd_q, rsp_gcd_d;
   logic               rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               seen_busy_q, seen_busy_d;

   // Outputs are decoded from registered state only, so eng_start is a
   // single-cycle pulse gated by the engine's own ready flag.
   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.eng_start = (state_q == ISSUE) && bus.eng_ready;
   assign bus.eng_ina   = eng_ina_q;
   assign bus.eng_inb   = eng_inb_q;
   assign bus.rsp_gcd   = rsp_gcd_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = (state_q != IDLE);

   // Next-state, operand capture, timeout counting and result capture.
   always_comb begin
      state_d     = state_q;
      eng_ina_d   = eng_ina_q;
      eng_inb_d   = eng_inb_q;
      rsp_gcd_d   = rsp_gcd_q;
      rsp_err_d   = rsp_err_q;
      count_d     = count_q;
      seen_busy_d = seen_busy_q;

      if ((state_q == ISSUE || state_q == WAIT_DONE) && count_q != CNT_MAX) begin
         count_d = count_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (bus.req_a == '0 || bus.req_b == '0) begin
                  rsp_gcd_d = bus.req_a | bus.req_b;
                  rsp_err_d = 1'b0;
                  state_d   = RESP;
               end else begin
                  eng_ina_d = bus.req_a;
                  eng_inb_d = bus.req_b;
                  count_d   = '0;
                  state_d   = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (bus.eng_ready) begin
               seen_busy_d = 1'b0;
               state_d     = WAIT_DONE;
            end else if (count_q == CNT_MAX) begin
               rsp_gcd_d = '0;
               rsp_err_d = 1'b1;
               state_d   = RESP;
            end
         end
         WAIT_DONE: begin
            if (!bus.eng_ready) begin
               seen_busy_d = 1'b1;
            end
            if (seen_busy_q && bus.eng_ready) begin
               rsp_gcd_d = bus.eng_out;
               rsp_err_d = 1'b0;
               state_d   = RESP;
            end else if (count_q == CNT_MAX) begin
               rsp_gcd_d = '0;
               rsp_err_d = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset; a reset drops any job.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= IDLE;
         eng_ina_q   <= '0;
         eng_inb_q   <= '0;
         rsp_gcd_q   <= '0;
         rsp_err_q   <= 1'b0;
         count_q     <= '0;
         seen_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         eng_ina_q   <= eng_ina_d;
         eng_inb_q   <= eng_inb_d;
         rsp_gcd_q   <= rsp_gcd_d;
         rsp_err_q   <= rsp_err_d;
         count_q     <= count_d;
         seen_busy_q <= seen_busy_d;
      end
   end
endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a behavioural engine model whose
// busy time is set per job (eng_lat). A busy time of 0 models an engine that
// never shows a busy phase, which must end in a timeout.
module tb_gcd_requester;
   localparam int WIDTH = 8;
   localparam int TMO   = 15;

   logic clk = 1'b0;
   logic nrst;
   logic busy;

   int total = 0;
   int bad   = 0;

   gcd_requester_if #(.WIDTH(WIDTH)) bus_if ();

   gcd_requester #(.WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus_if),
      .busy (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] gcd_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] p, q, t;
      p = x;
      q = y;
      while (q != 0) begin
         t = p % q;
         p = q;
         q = t;
      end
      return p;
   endfunction

   // Engine model: sampling start while idle makes it busy for eng_lat cycles.
   int               eng_cnt = 0;
   int               eng_lat = 3;
   logic [WIDTH-1:0] eng_res = '0;
   assign bus_if.eng_ready = (eng_cnt == 0);
   assign bus_if.eng_out   = eng_res;

   always @(posedge clk) begin
      if (bus_if.eng_start && bus_if.eng_ready) begin
         eng_cnt <= eng_lat;
         eng_res <= gcd_model(bus_if.eng_ina, bus_if.eng_inb);
      end else if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
      end
   end

   // Start-pulse monitor, sampled mid-cycle.
   int               start_cnt = 0;
   int               start_bad = 0;
   logic [WIDTH-1:0] last_ina = '0;
   logic [WIDTH-1:0] last_inb = '0;
   always @(negedge clk) begin
      if (bus_if.eng_start) begin
         start_cnt = start_cnt + 1;
         last_ina  = bus_if.eng_ina;
         last_inb  = bus_if.eng_inb;
         if (!bus_if.eng_ready) start_bad = start_bad + 1;
      end
   end

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] gcd;
      logic             err;
      int               lat;
      int               starts;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Runs one job with rsp_ready high; lat counts negedges from the accept edge
   // to the first one showing rsp_valid.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output int lat, output int starts,
                                output logic [WIDTH-1:0] gcd, output logic err,
                                output logic busy_after);
      int s0;
      int n;
      @(negedge clk);
      s0 = start_cnt;
      bus_if.req_valid = 1'b1;
      bus_if.req_a     = a;
      bus_if.req_b     = b;
      n = 0;
      while (!bus_if.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      lat = 1;
      while (!bus_if.rsp_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      gcd = bus_if.rsp_gcd;
      err = bus_if.rsp_err;
      @(negedge clk);
      busy_after = busy;
      starts = start_cnt - s0;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int               lat;
      int               starts;
      int               s0;
      int               n;
      int               leak;
      logic [WIDTH-1:0] g;
      logic             e;
      logic             ba;

      vecs[0] = '{8'd12,  8'd8,   8'd4,   1'b0, 6, 1};
      vecs[1] = '{8'd0,   8'd9,   8'd9,   1'b0, 1, 0};
      vecs[2] = '{8'd5,   8'd0,   8'd5,   1'b0, 1, 0};
      vecs[3] = '{8'd0,   8'd0,   8'd0,   1'b0, 1, 0};
      vecs[4] = '{8'd100, 8'd75,  8'd25,  1'b0, 6, 1};
      vecs[5] = '{8'd1,   8'd200, 8'd1,   1'b0, 6, 1};
      vecs[6] = '{8'd255, 8'd255, 8'd255, 1'b0, 6, 1};

      nrst             = 1'b0;
      bus_if.req_valid = 1'b0;
      bus_if.req_a     = '0;
      bus_if.req_b     = '0;
      bus_if.rsp_ready = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("rst_rsp_valid", bus_if.rsp_valid, 0);
      checkOutput("rst_eng_start", bus_if.eng_start, 0);
      checkOutput("rst_rsp_gcd",   bus_if.rsp_gcd,   0);
      checkOutput("rst_rsp_err",   bus_if.rsp_err,   0);
      checkOutput("rst_eng_ina",   bus_if.eng_ina,   0);
      checkOutput("rst_eng_inb",   bus_if.eng_inb,   0);
      checkOutput("rst_busy",      busy,             0);
      nrst = 1'b1;
      @(negedge clk);
      checkOutput("rel_req_ready", bus_if.req_ready, 1);

      // Table of single jobs, engine busy for 3 cycles.
      eng_lat = 3;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, lat, starts, g, e, ba);
         checkOutput($sformatf("vec%0d_gcd", i),    g,      vecs[i].gcd);
         checkOutput($sformatf("vec%0d_err", i),    e,      vecs[i].err);
         checkOutput($sformatf("vec%0d_lat", i),    lat,    vecs[i].lat);
         checkOutput($sformatf("vec%0d_starts", i), starts, vecs[i].starts);
         checkOutput($sformatf("vec%0d_busy", i),   ba,     0);
         if (vecs[i].starts != 0) begin
            checkOutput($sformatf("vec%0d_ina", i), last_ina, vecs[i].a);
            checkOutput($sformatf("vec%0d_inb", i), last_inb, vecs[i].b);
         end
      end

      // Back-to-back with req_valid held high across both jobs.
      @(negedge clk);
      s0 = start_cnt;
      bus_if.req_valid = 1'b1;
      bus_if.req_a     = 8'd7;
      bus_if.req_b     = 8'd7;
      n = 0;
      while (!bus_if.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus_if.req_a = 8'd255;
      bus_if.req_b = 8'd1;
      leak = 0;
      n = 0;
      while (!bus_if.rsp_valid && n < 200) begin
         if (bus_if.req_ready) leak++;
         @(negedge clk);
         n++;
      end
      checkOutput("b2b_first_gcd", bus_if.rsp_gcd,   7);
      checkOutput("b2b_ready_low", leak,             0);
      checkOutput("b2b_resp_rdy",  bus_if.req_ready, 0);
      @(negedge clk);
      checkOutput("b2b_idle_rdy",  bus_if.req_ready, 1);
      checkOutput("b2b_idle_vld",  bus_if.rsp_valid, 0);
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      checkOutput("b2b_second_busy", busy, 1);
      n = 0;
      while (!bus_if.rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("b2b_second_gcd", bus_if.rsp_gcd,  1);
      checkOutput("b2b_starts",     start_cnt - s0,  2);
      @(negedge clk);

      // Downstream stall for 5 cycles while another request is pending.
      bus_if.rsp_ready = 1'b0;
      s0 = start_cnt;
      bus_if.req_valid = 1'b1;
      bus_if.req_a     = 8'd36;
      bus_if.req_b     = 8'd24;
      n = 0;
      while (!bus_if.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus_if.req_a = 8'd3;
      bus_if.req_b = 8'd3;
      n = 0;
      while (!bus_if.rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("stall%0d_valid", k), bus_if.rsp_valid, 1);
         checkOutput($sformatf("stall%0d_gcd", k),   bus_if.rsp_gcd,   12);
         checkOutput($sformatf("stall%0d_err", k),   bus_if.rsp_err,   0);
         checkOutput($sformatf("stall%0d_rdy", k),   bus_if.req_ready, 0);
         @(negedge clk);
      end
      bus_if.rsp_ready = 1'b1;
      bus_if.req_valid = 1'b0;
      @(negedge clk);
      checkOutput("stall_idle_busy",  busy,             0);
      checkOutput("stall_idle_valid", bus_if.rsp_valid, 0);
      checkOutput("stall_starts",     start_cnt - s0,   1);

      // Engine that never goes busy: its early ready must not be taken as done.
      eng_lat = 0;
      applyStimulus(8'd21, 8'd14, lat, starts, g, e, ba);
      checkOutput("stale_err",    e,      1);
      checkOutput("stale_gcd",    g,      0);
      checkOutput("stale_lat",    lat,    TMO + 2);
      checkOutput("stale_starts", starts, 1);

      // Engine stuck busy: job times out after the counter reaches TIMEOUT.
      eng_lat = 100;
      applyStimulus(8'd9, 8'd6, lat, starts, g, e, ba);
      checkOutput("tmo_err",    e,      1);
      checkOutput("tmo_gcd",    g,      0);
      checkOutput("tmo_lat",    lat,    TMO + 2);
      checkOutput("tmo_starts", starts, 1);
      checkOutput("tmo_busy",   ba,     0);
      n = 0;
      while (!bus_if.eng_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("tmo_drain", bus_if.eng_ready, 1);

      // Reset in the middle of a job while the engine is still busy.
      eng_lat = 8;
      @(negedge clk);
      bus_if.req_valid = 1'b1;
      bus_if.req_a     = 8'd20;
      bus_if.req_b     = 8'd15;
      n = 0;
      while (!bus_if.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_busy",  busy,             0);
      checkOutput("mid_rst_valid", bus_if.rsp_valid, 0);
      checkOutput("mid_rst_start", bus_if.eng_start, 0);
      checkOutput("mid_rst_rdy",   bus_if.req_ready, 1);
      nrst = 1'b1;
      eng_lat = 3;
      applyStimulus(8'd10, 8'd4, lat, starts, g, e, ba);
      checkOutput("post_rst_gcd",    g,        2);
      checkOutput("post_rst_err",    e,        0);
      checkOutput("post_rst_starts", starts,   1);
      checkOutput("post_rst_waited", lat > 6,  1);
      checkOutput("start_gated",     start_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gcd_requester.md
Name: gcd_requester

Overview:
- Client-side sequencer for the subtractive GCD engine: it is the initiator on the engine's start/ready handshake.
- Accepts operand pairs from an upstream valid/ready port and drives the engine's start, ina and inb.
- Waits for completion, captures the engine result and presents it downstream on a valid/ready port.
- Resolves zero operands locally, which the engine cannot terminate on, and bounds every job with a timeout.

Parameters:
- WIDTH, 8, operand and result width; must equal the engine's data width.
- TIMEOUT, 1023, maximum cycles a job may spend in ISSUE plus WAIT_DONE before it is aborted.

Ports:
- clk  in  1  clock; all state updates on posedge.
- nrst  in  1  synchronous active-low reset.
- req_valid  in  1  upstream has an operand pair.
- req_ready  out  1  block accepts a pair this cycle.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  downstream consumes the result.
- rsp_gcd  out  WIDTH  gcd(A,B); 0 when rsp_err=1.
- rsp_err  out  1  job aborted by timeout.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_ina  out  WIDTH  operand A to the engine.
- eng_inb  out  WIDTH  operand B to the engine.
- eng_ready  in  1  engine idle (1) or busy (0).
- eng_out  in  WIDTH  engine result; valid when eng_ready returns high after a busy phase.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on nrst, sampled only at posedge clk.
- Reset values: state=IDLE, eng_start=0, rsp_valid=0, rsp_err=0, rsp_gcd=0, eng_ina=0, eng_inb=0, timeout counter=0, seen_busy=0.
- Reset mid-job: the job is dropped with no response. A subsequent ISSUE still waits for eng_ready=1, so a still-busy engine is not restarted early.
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE: req_ready=1, including the first cycle after reset release; req_ready=0 in all other states.
  - On req_valid&req_ready, register A and B.
  - If A==0 or B==0: set rsp_gcd=A|B (gcd(0,0)=0), go to RESP; the engine is not touched.
  - Otherwise: drive eng_ina=A and eng_inb=B, clear the counter, go to ISSUE.
- ISSUE: eng_start = eng_ready, combinational from the registered state, so the pulse lasts exactly one cycle.
  - When eng_ready=1: go to WAIT_DONE next cycle with seen_busy=0.
  - If the engine is not yet ready, remain in ISSUE.
- WAIT_DONE:
  - Set seen_busy when eng_ready=0.
  - When seen_busy=1 and eng_ready=1: capture rsp_gcd=eng_out, rsp_err=0, go to RESP.
  - eng_ready=1 before any busy cycle is ignored, which guards against a stale result.
- eng_ina and eng_inb are held stable from entry to ISSUE until RESP.
- Timeout:
  - The counter increments each cycle in ISSUE and WAIT_DONE and saturates.
  - When count==TIMEOUT and the job is not completing that cycle: go to RESP with rsp_err=1, rsp_gcd=0.
  - Completion and timeout in the same cycle: completion wins.
- RESP: rsp_valid=1; rsp_gcd and rsp_err are held stable until rsp_ready=1, then return to IDLE. There is no bypass: a new request is accepted only in IDLE, one cycle after the handshake at the earliest.
- Latency:
  - Zero-operand job: accept edge to rsp_valid = 1 cycle.
  - Engine job: 2 cycles plus the engine busy time.
- Widths: all data is WIDTH bits and unsigned. The counter is clog2(TIMEOUT+1) bits.

Test Plan:
- (12,8), idle engine model, rsp_ready=1 -> exactly one eng_start pulse with ina=12, inb=8; rsp_gcd=4, rsp_err=0; busy drops after the handshake.
- (0,9), then (5,0), then (0,0) -> rsp_gcd=9, 5, 0 respectively; eng_start never asserted; each rsp_valid arrives 1 cycle after acceptance.
- (7,7), then (255,1) back-to-back with req_valid held high -> results 7, then 1; req_ready low throughout the first job; the second pair is accepted only in IDLE.
- (36,24) with rsp_ready held low 5 cycles after rsp_valid -> rsp_valid, rsp_gcd=12 and rsp_err stay stable for 5 cycles; no new request accepted; IDLE the cycle after rsp_ready=1.
- TIMEOUT=15, engine model holds eng_ready=0 after start, request (9,6) -> rsp_valid with rsp_err=1 and rsp_gcd=0 after the counter reaches 15; eng_start pulsed once only.
- Assert nrst=0 for 1 cycle while in WAIT_DONE -> next cycle state is IDLE with rsp_valid=0 and eng_start=0; a following (10,4) waits for eng_ready=1 and returns 2.
